// File: rtl/battle_board_if.sv
`default_nettype none
// ============================================================================
// Module      : battle_board_if
// Description : Placement/shot request-response and read-port bundle.
// Revision    : 1.0  initial release
// ============================================================================
interface battle_board_if #(
  parameter int BOARD_W    = 10,
  parameter int BOARD_H    = 10,
  parameter int SHIP_CELLS = 10
);
  localparam int XW = $clog2(BOARD_W);
  localparam int YW = $clog2(BOARD_H);
  localparam int CW = $clog2(SHIP_CELLS + 1);

  logic          new_game;
  logic          place_req;
  logic          place_player;
  logic [XW-1:0] place_x;
  logic [YW-1:0] place_y;
  logic          place_done;
  logic          place_ok;
  logic          shot_req;
  logic          shot_player;
  logic [XW-1:0] shot_x;
  logic [YW-1:0] shot_y;
  logic          shot_done;
  logic [1:0]    shot_result;
  logic [XW-1:0] rd_x;
  logic [YW-1:0] rd_y;
  logic [1:0]    rd_code_host;
  logic [1:0]    rd_code_guest;
  logic [1:0]    phase;
  logic          turn;
  logic [CW-1:0] count_host;
  logic [CW-1:0] count_guest;
  logic [CW-1:0] hits_host;
  logic [CW-1:0] hits_guest;
  logic          winner;

  modport master (
    output new_game, place_req, place_player, place_x, place_y,
    output shot_req, shot_player, shot_x, shot_y, rd_x, rd_y,
    input  place_done, place_ok, shot_done, shot_result,
    input  rd_code_host, rd_code_guest, phase, turn,
    input  count_host, count_guest, hits_host, hits_guest, winner
  );

  modport slave (
    input  new_game, place_req, place_player, place_x, place_y,
    input  shot_req, shot_player, shot_x, shot_y, rd_x, rd_y,
    output place_done, place_ok, shot_done, shot_result,
    output rd_code_host, rd_code_guest, phase, turn,
    output count_host, count_guest, hits_host, hits_guest, winner
  );
endinterface
`default_nettype wire

// File: rtl/battle_board.sv
`default_nettype none
// ============================================================================
// Module      : battle_board
// Description : Two-player battleship board store: placement, shots, win.
// Revision    : 1.0  initial release
// ============================================================================
module battle_board #(
  parameter int BOARD_W    = 10,
  parameter int BOARD_H    = 10,
  parameter int SHIP_CELLS = 10
) (
  input  logic          clk,
  input  logic          rst,
  battle_board_if.slave bb
);
  localparam int XW = $clog2(BOARD_W);
  localparam int YW = $clog2(BOARD_H);
  localparam int CW = $clog2(SHIP_CELLS + 1);
  localparam int XP = XW + 1;
  localparam int YP = YW + 1;

  localparam logic [XP-1:0] c_W     = XP'(BOARD_W);
  localparam logic [YP-1:0] c_H     = YP'(BOARD_H);
  localparam logic [CW-1:0] c_SHIPS = CW'(SHIP_CELLS);
  localparam logic [CW-1:0] c_ONE   = CW'(1);

  localparam logic [1:0] c_EMPTY = 2'b00;
  localparam logic [1:0] c_SHIP  = 2'b01;
  localparam logic [1:0] c_MISS  = 2'b10;
  localparam logic [1:0] c_HIT   = 2'b11;

  typedef enum logic [1:0] {
    PH_PLACE  = 2'b00,
    PH_BATTLE = 2'b01,
    PH_OVER   = 2'b10
  } phase_e;

  // Index [0] is the host board, [1] the guest board.
  logic [1:0]    r_board [2][BOARD_H][BOARD_W];
  logic [CW-1:0] r_count [2];
  logic [CW-1:0] r_hits  [2];
  phase_e        r_phase;
  logic          r_turn;
  logic          r_winner;
  logic          r_place_done;
  logic          r_place_ok;
  logic          r_shot_done;
  logic [1:0]    r_shot_result;
  logic [1:0]    r_rd_host;
  logic [1:0]    r_rd_guest;

  logic          w_place_inr;
  logic [1:0]    w_place_cell;
  logic          w_place_acc;
  logic [CW-1:0] w_cnt_post_h;
  logic [CW-1:0] w_cnt_post_g;
  logic          w_both_full;
  logic          w_shot_inr;
  logic          w_tgt;
  logic [1:0]    w_shot_cell;
  logic          w_shot_acc;
  logic          w_shot_hit;
  logic [CW-1:0] w_hits_post;
  logic          w_shot_win;
  logic [1:0]    w_shot_res;
  logic          w_rd_inr;
  logic [1:0]    w_rd_host;
  logic [1:0]    w_rd_guest;

  assign w_place_inr  = ({1'b0, bb.place_x} < c_W) && ({1'b0, bb.place_y} < c_H);
  assign w_place_cell = r_board[bb.place_player][bb.place_y][bb.place_x];
  assign w_place_acc  = bb.place_req && (r_phase == PH_PLACE) && w_place_inr &&
                        (w_place_cell == c_EMPTY) &&
                        (r_count[bb.place_player] < c_SHIPS);

  // Post-write counts decide the PLACE -> BATTLE move on the same edge.
  assign w_cnt_post_h = r_count[0] + ((w_place_acc && !bb.place_player) ? c_ONE : '0);
  assign w_cnt_post_g = r_count[1] + ((w_place_acc &&  bb.place_player) ? c_ONE : '0);
  assign w_both_full  = (w_cnt_post_h == c_SHIPS) && (w_cnt_post_g == c_SHIPS);

  assign w_shot_inr  = ({1'b0, bb.shot_x} < c_W) && ({1'b0, bb.shot_y} < c_H);
  assign w_tgt       = ~bb.shot_player;
  assign w_shot_cell = r_board[w_tgt][bb.shot_y][bb.shot_x];
  assign w_shot_acc  = bb.shot_req && (r_phase == PH_BATTLE) &&
                       (bb.shot_player == r_turn) && w_shot_inr && !w_shot_cell[1];
  assign w_shot_hit  = (w_shot_cell == c_SHIP);
  assign w_hits_post = r_hits[bb.shot_player] + c_ONE;
  assign w_shot_win  = w_shot_hit && (w_hits_post == c_SHIPS);
  assign w_shot_res  = !w_shot_acc ? 2'b00 :
                       !w_shot_hit ? 2'b01 :
                       w_shot_win  ? 2'b11 : 2'b10;

  assign w_rd_inr   = ({1'b0, bb.rd_x} < c_W) && ({1'b0, bb.rd_y} < c_H);
  assign w_rd_host  = w_rd_inr ? r_board[0][bb.rd_y][bb.rd_x] : c_EMPTY;
  assign w_rd_guest = w_rd_inr ? r_board[1][bb.rd_y][bb.rd_x] : c_EMPTY;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < 2; p++) begin
        for (int y = 0; y < BOARD_H; y++)
          for (int x = 0; x < BOARD_W; x++) r_board[p][y][x] <= c_EMPTY;
        r_count[p] <= '0;
        r_hits[p]  <= '0;
      end
      r_phase <= PH_PLACE;  r_turn <= 1'b0;  r_winner <= 1'b0;
      r_place_done <= 1'b0; r_place_ok <= 1'b0;
      r_shot_done  <= 1'b0; r_shot_result <= 2'b00;
      r_rd_host    <= 2'b00; r_rd_guest <= 2'b00;
    end else if (bb.new_game) begin
      for (int p = 0; p < 2; p++) begin
        for (int y = 0; y < BOARD_H; y++)
          for (int x = 0; x < BOARD_W; x++) r_board[p][y][x] <= c_EMPTY;
        r_count[p] <= '0;
        r_hits[p]  <= '0;
      end
      r_phase <= PH_PLACE;  r_turn <= 1'b0;  r_winner <= 1'b0;
      r_place_done <= 1'b0; r_place_ok <= 1'b0;
      r_shot_done  <= 1'b0; r_shot_result <= 2'b00;
      r_rd_host    <= 2'b00; r_rd_guest <= 2'b00;
    end else begin
      r_rd_host  <= w_rd_host;
      r_rd_guest <= w_rd_guest;

      r_place_done <= bb.place_req;
      if (bb.place_req) r_place_ok <= w_place_acc;
      if (w_place_acc) begin
        r_board[bb.place_player][bb.place_y][bb.place_x] <= c_SHIP;
        r_count[0] <= w_cnt_post_h;
        r_count[1] <= w_cnt_post_g;
        if (w_both_full) begin
          r_phase <= PH_BATTLE;
          r_turn  <= 1'b0;
        end
      end

      // A hit keeps the turn with the shooter; a miss passes it over.
      r_shot_done <= bb.shot_req;
      if (bb.shot_req) r_shot_result <= w_shot_res;
      if (w_shot_acc) begin
        r_board[w_tgt][bb.shot_y][bb.shot_x] <= w_shot_hit ? c_HIT : c_MISS;
        if (w_shot_hit) begin
          r_hits[bb.shot_player] <= w_hits_post;
          if (w_shot_win) begin
            r_phase  <= PH_OVER;
            r_winner <= bb.shot_player;
          end
        end else begin
          r_turn <= ~r_turn;
        end
      end
    end
  end

  assign bb.place_done    = r_place_done;
  assign bb.place_ok      = r_place_ok;
  assign bb.shot_done     = r_shot_done;
  assign bb.shot_result   = r_shot_result;
  assign bb.rd_code_host  = r_rd_host;
  assign bb.rd_code_guest = r_rd_guest;
  assign bb.phase         = r_phase;
  assign bb.turn          = r_turn;
  assign bb.count_host    = r_count[0];
  assign bb.count_guest   = r_count[1];
  assign bb.hits_host     = r_hits[0];
  assign bb.hits_guest    = r_hits[1];
  assign bb.winner        = r_winner;
endmodule
`default_nettype wire

// File: doc/battle_board.md
Name: battle_board

Overview:
- Parametrised two-player battleship board store with a per-player placement phase, turn-based shot resolution and game-over detection.
- Holds one BOARD_W x BOARD_H array of 2-bit cell codes per player (host = player 0, guest = player 1).
- Sits between the mouse/UART game-control logic and the board renderers; renderers scan it through a registered read port.

Parameters:
- BOARD_W, 10, columns per board (2..16)
- BOARD_H, 10, rows per board (2..16)
- SHIP_CELLS, 10, ship cells each player must place; also the number of hits that wins (1..BOARD_W*BOARD_H)
- Derived, not overridable: XW = $clog2(BOARD_W), YW = $clog2(BOARD_H), CW = $clog2(SHIP_CELLS+1)

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- new_game  in  1  synchronous clear pulse
- place_req  in  1  placement request strobe
- place_player  in  1  board to place on (0 host, 1 guest)
- place_x  in  XW  column
- place_y  in  YW  row
- place_done  out  1  one-cycle placement response strobe
- place_ok  out  1  placement accepted (valid with place_done)
- shot_req  in  1  shot request strobe
- shot_player  in  1  shooting player; the target is the other board
- shot_x  in  XW  column
- shot_y  in  YW  row
- shot_done  out  1  one-cycle shot response strobe
- shot_result  out  2  00 reject, 01 miss, 10 hit, 11 hit+win
- rd_x  in  XW  read column
- rd_y  in  YW  read row
- rd_code_host  out  2  host cell at (rd_x, rd_y)
- rd_code_guest  out  2  guest cell at (rd_x, rd_y)
- phase  out  2  00 PLACE, 01 BATTLE, 10 OVER
- turn  out  1  player allowed to shoot
- count_host  out  CW  host ship cells placed
- count_guest  out  CW  guest ship cells placed
- hits_host  out  CW  hits scored by host
- hits_guest  out  CW  hits scored by guest
- winner  out  1  valid when phase = OVER

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk, rising edge.
- Reset state and values:
  - every cell of both boards = 00; all counters = 0
  - phase = PLACE; turn = 0; winner = 0
  - all strobes, place_ok, shot_result and rd_code_* = 0
- new_game = 1 forces the reset state on the next edge from any phase. It overrides place_req and shot_req in the same cycle; those requests get no response strobe.
- Cell codes: 00 EMPTY, 01 SHIP, 10 MISS, 11 HIT.
- Placement: a request is accepted only if all of the following hold:
  - phase = PLACE
  - place_x < BOARD_W and place_y < BOARD_H
  - the target cell is EMPTY
  - that player's count < SHIP_CELLS
- Accepted placement: the cell becomes SHIP and the player's count increments on the same edge. place_done = 1 and place_ok = 1 in the following cycle.
- Rejected placement: no state change; place_done = 1, place_ok = 0. This covers duplicate cell, full count, out-of-range coordinates and wrong phase.
- PLACE -> BATTLE happens on the edge where both counts equal SHIP_CELLS, using post-write values. It is visible in the same cycle as the final place_done. turn = 0 on entry.
- Shot: accepted only if all of the following hold:
  - phase = BATTLE
  - shot_player = turn
  - coordinates are in range
  - the target cell on the opponent board is EMPTY or SHIP
- Shot on SHIP: cell -> HIT, shooter's hits increment, turn is unchanged (the shooter fires again), shot_result = 10.
- Shot on EMPTY: cell -> MISS, turn toggles, shot_result = 01.
- Winning shot: if a hit brings the shooter's hits to SHIP_CELLS, shot_result = 11, phase -> OVER and winner = shooter on the same edge.
- Rejected shot: no state change, shot_result = 00. This covers a repeat on HIT/MISS, wrong turn, out of range, PLACE and OVER.
- Shot latency: shot_done and shot_result are registered, 1 cycle after shot_req.
- Response hold: place_ok and shot_result keep their last value until the next response. The done strobes are high for exactly one cycle.
- Simultaneous place_req and shot_req: both are evaluated independently. Because the phases are exclusive, at most one is accepted, and both done strobes fire.
- Read port: rd_code_host and rd_code_guest are registered with 1-cycle latency and update every cycle.
  - They return the pre-write value when a write hits the same cell on the same edge.
  - Out-of-range rd_x/rd_y returns 00.
- Counters never exceed SHIP_CELLS. OVER is held until new_game or rst.

Test Plan:
- Reset, then read all cells -> rd_code_* = 00, phase = 00, all counts = 0; rst asserted mid-BATTLE clears every cell asynchronously.
- Place host (3,4) twice -> first response place_ok = 1, count_host = 1, rd_code_host(3,4) = 01 after 1 cycle; second response place_ok = 0, count unchanged; place at x = 10 -> place_ok = 0.
- Place 10 cells on each board -> phase = 01 in the cycle of the 20th place_done; an 11th host placement -> place_ok = 0.
- BATTLE, turn 0:
  - host shoots a guest EMPTY cell -> result 01, turn = 1, cell = 10
  - guest shoots a host SHIP cell -> result 10, turn stays 1
  - guest shoots the same cell again -> result 00
  - host fires out of turn -> result 00
- SHIP_CELLS = 1 build: host hits the single guest ship -> result 11, phase = 10, winner = 0; a later shot -> 00.
- new_game pulsed together with shot_req -> no shot_done, and the next cycle reads the reset state.
